qdense_tile_seq: RTL and testbench

- Sequencer that folds a wide dense layer (NT*YT outputs) onto one combinational qdense tile (XD inputs x YT outputs).
- Accepts one input vector through a valid/ready handshake and holds it for the whole vector.
- Issues one weight/bias fetch per output tile to a synchronous weight memory, drives the tile, and captures each tile result into an output buffer.
- Presents the complete output vector through a valid/ready handshake.
- Sits between the activation stream and the qdense tile/weight ROM in a layer pipeline.

---
 rtl/qdense_tile_seq.sv | 104 ++++++++++
 tb/tb_qdense_tile_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdense_tile_seq.sv
// Folds an NT*YT-output dense layer onto one XD x YT combinational qdense tile,
// fetching one weight/bias tile per cycle and collecting results into an output buffer.
//
// state | meaning
// IDLE  | waiting for an input vector (s_ready high)
// RUN   | issuing one weight fetch per cycle, tiles 0..NT-1
// DRAIN | no fetch; last tile result is captured
// OUT   | full output vector presented until m_ready
module qdense_tile_seq #(
    parameter  int XD = 8,
    parameter  int YT = 8,
    parameter  int NT = 4,
    parameter  int XB = 8,
    parameter  int KB = 8,
    localparam int YB = XB + KB + $clog2(XD + 1),
    localparam int AW = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [XD*XB-1:0]       s_x,
    output logic                   w_en,
    output logic [AW-1:0]          w_addr,
    input  logic [XD*YT*KB-1:0]    w_k,
    input  logic [YT*KB-1:0]       w_b,
    output logic [XD*XB-1:0]       t_x,
    output logic [XD*YT*KB-1:0]    t_k,
    output logic [YT*KB-1:0]       t_b,
    input  logic [YT*YB-1:0]       t_y,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NT*YT*YB-1:0]    m_y
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                state;
    logic [XD*XB-1:0]      x_reg;
    logic [AW-1:0]         fcnt;
    logic                  wv;
    logic [AW-1:0]         wa;
    logic [NT*YT*YB-1:0]   y_buf;

    assign s_ready = (state == IDLE);
    assign t_x     = x_reg;
    assign t_k     = w_k;
    assign t_b     = w_b;
    assign m_y     = y_buf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            x_reg   <= '0;
            fcnt    <= '0;
            wv      <= 1'b0;
            wa      <= '0;
            y_buf   <= '0;
            w_en    <= 1'b0;
            w_addr  <= '0;
            m_valid <= 1'b0;
        end else begin
            // Memory data for the address issued last cycle is on t_y now.
            wv <= w_en;
            wa <= w_addr;
            if (wv)
                y_buf[int'(wa)*YT*YB +: YT*YB] <= t_y;

            case (state)
                IDLE: begin
                    if (s_valid) begin
                        x_reg  <= s_x;
                        fcnt   <= '0;
                        w_en   <= 1'b1;
                        w_addr <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (fcnt == AW'(NT - 1)) begin
                        w_en   <= 1'b0;
                        w_addr <= '0;
                        state  <= DRAIN;
                    end else begin
                        fcnt   <= fcnt + 1'b1;
                        w_addr <= fcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    m_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdense_tile_seq.sv
// Directed bench for qdense_tile_seq: a 3-tile instance and a 1-tile instance,
// each fed by a behavioural weight memory and a behavioural qdense tile.
module tb_qdense_tile_seq;
    localparam int XD = 4;
    localparam int YT = 2;
    localparam int NT = 3;
    localparam int XB = 8;
    localparam int KB = 8;
    localparam int YB = 19;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int mode  = 0;

    logic                  s_valid, s_ready, w_en, m_valid, m_ready;
    logic [XD*XB-1:0]      s_x, t_x;
    logic [AW-1:0]         w_addr;
    logic [XD*YT*KB-1:0]   w_k, t_k;
    logic [YT*KB-1:0]      w_b, t_b;
    logic [YT*YB-1:0]      t_y;
    logic [NT*YT*YB-1:0]   m_y;

    logic                  s_valid1, s_ready1, w_en1, m_valid1, m_ready1;
    logic [XD*XB-1:0]      s_x1, t_x1;
    logic [0:0]            w_addr1;
    logic [XD*YT*KB-1:0]   w_k1, t_k1;
    logic [YT*KB-1:0]      w_b1, t_b1;
    logic [YT*YB-1:0]      t_y1;
    logic [YT*YB-1:0]      m_y1;

    qdense_tile_seq #(.XD(XD), .YT(YT), .NT(NT), .XB(XB), .KB(KB)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
        .w_en(w_en), .w_addr(w_addr), .w_k(w_k), .w_b(w_b),
        .t_x(t_x), .t_k(t_k), .t_b(t_b), .t_y(t_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y));

    qdense_tile_seq #(.XD(XD), .YT(YT), .NT(1), .XB(XB), .KB(KB)) dut1 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid1), .s_ready(s_ready1), .s_x(s_x1),
        .w_en(w_en1), .w_addr(w_addr1), .w_k(w_k1), .w_b(w_b1),
        .t_x(t_x1), .t_k(t_k1), .t_b(t_b1), .t_y(t_y1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_y(m_y1));

    function automatic logic [KB-1:0] kval(input int t);
        return (mode == 0) ? KB'(t + 1) : 8'h80;
    endfunction

    function automatic logic [KB-1:0] bval(input int t);
        return (mode == 0) ? KB'(t) : 8'h80;
    endfunction

    function automatic logic [YT*YB-1:0] tile_f(input logic [XD*XB-1:0] x,
                                                input logic [XD*YT*KB-1:0] k,
                                                input logic [YT*KB-1:0] b);
        logic [YT*YB-1:0] y;
        int acc;
        y = '0;
        for (int j = 0; j < YT; j++) begin
            acc = int'($signed(b[j*KB +: KB]));
            for (int i = 0; i < XD; i++)
                acc += int'($signed(x[i*XB +: XB])) * int'($signed(k[(j*XD+i)*KB +: KB]));
            y[j*YB +: YB] = acc[YB-1:0];
        end
        return y;
    endfunction

    assign t_y  = tile_f(t_x, t_k, t_b);
    assign t_y1 = tile_f(t_x1, t_k1, t_b1);

    initial begin
        w_k = '0; w_b = '0; w_k1 = '0; w_b1 = '0;
    end

    always @(posedge clk) begin
        if (w_en) begin
            w_k <= {XD*YT{kval(int'(w_addr))}};
            w_b <= {YT{bval(int'(w_addr))}};
        end
        if (w_en1) begin
            w_k1 <= {XD*YT{kval(int'(w_addr1))}};
            w_b1 <= {YT{bval(int'(w_addr1))}};
        end
    end

    localparam logic [XD*XB-1:0] X_BASIC = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [XD*XB-1:0] X_NEG   = {4{8'h80}};

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
    task automatic send(input logic [XD*XB-1:0] x);
        s_x = x;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        n_vec++;
        if (w_en !== 1'b0 || w_addr !== '0 || m_valid !== 1'b0 || m_y !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: w_en=%b w_addr=%0d m_valid=%b m_y=%h, want all 0",
                     w_en, w_addr, m_valid, m_y);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1 || s_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_s_ready: got %b/%b want 1/1", s_ready, s_ready1);
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [YB-1:0] got;
        mode = 0;
        send(X_BASIC);
        cyc = 1;
        while (m_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL basic_latency: m_valid at cycle %0d want 5", cyc);
        end
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < YT; j++) begin
                got = m_y[(t*YT+j)*YB +: YB];
                n_vec++;
                if (got !== YB'(10*(t+1) + t)) begin
                    n_err++;
                    $display("FAIL basic_y[%0d][%0d]: got %0d want %0d", t, j, got, 10*(t+1) + t);
                end
            end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_return: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_extreme();
        int cyc;
        logic [YB-1:0] got;
        mode = 1;
        @(negedge clk);
        send(X_NEG);
        cyc = 1;
        while (m_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int e = 0; e < NT*YT; e++) begin
            got = m_y[e*YB +: YB];
            n_vec++;
            if (got !== 19'd65408) begin
                n_err++;
                $display("FAIL extreme_y[%0d]: got %0d want 65408", e, got);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        mode = 0;
    endtask

    task automatic test_fetch_pattern();
        logic          exp_en;
        logic [AW-1:0] exp_addr;
        mode = 0;
        @(negedge clk);
        send(X_BASIC);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            exp_en   = (cyc >= 1 && cyc <= NT);
            exp_addr = exp_en ? AW'(cyc - 1) : '0;
            n_vec++;
            if (w_en !== exp_en || w_addr !== exp_addr || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_c%0d: w_en=%b w_addr=%0d s_ready=%b want %b/%0d/0",
                         cyc, w_en, w_addr, s_ready, exp_en, exp_addr);
            end
            s_x = X_NEG;
            s_valid = (cyc == 2 || cyc == 3);
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_vec++;
        if (m_valid !== 1'b1 || m_y[0 +: YB] !== 19'd10 || m_y[(NT*YT-1)*YB +: YB] !== 19'd32) begin
            n_err++;
            $display("FAIL fetch_ignored_svalid: m_valid=%b y0=%0d ylast=%0d want 1/10/32",
                     m_valid, m_y[0 +: YB], m_y[(NT*YT-1)*YB +: YB]);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [NT*YT*YB-1:0] exp_vec;
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < YT; j++)
                exp_vec[(t*YT+j)*YB +: YB] = YB'(10*(t+1) + t);
        mode = 0;
        @(negedge clk);
        send(X_BASIC);
        cyc = 1;
        while (m_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || w_en !== 1'b0 || m_y !== exp_vec) begin
                n_err++;
                $display("FAIL backpressure_hold%0d: m_valid=%b s_ready=%b w_en=%b m_y=%h want 1/0/0/%h",
                         i, m_valid, s_ready, w_en, m_y, exp_vec);
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [YB-1:0] got;
        mode = 1;
        @(negedge clk);
        send(X_NEG);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_vec++;
        if (w_en !== 1'b0 || w_addr !== '0 || m_valid !== 1'b0 || m_y !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: w_en=%b w_addr=%0d m_valid=%b m_y=%h want all 0",
                     w_en, w_addr, m_valid, m_y);
        end
        @(negedge clk);
        rstn = 1'b1;
        mode = 0;
        @(negedge clk);
        send(X_BASIC);
        cyc = 1;
        while (m_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL midrun_latency: m_valid at cycle %0d want 5", cyc);
        end
        for (int t = 0; t < NT; t++) begin
            got = m_y[t*YT*YB +: YB];
            n_vec++;
            if (got !== YB'(10*(t+1) + t)) begin
                n_err++;
                $display("FAIL midrun_y[%0d]: got %0d want %0d", t, got, 10*(t+1) + t);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_nt1_back_to_back();
        mode = 0;
        @(negedge clk);
        s_x1 = X_BASIC;
        s_valid1 = 1'b1;
        m_ready1 = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            n_vec++;
            if (s_ready1 !== (cyc % 4 == 0) || w_en1 !== (cyc % 4 == 1) ||
                m_valid1 !== (cyc % 4 == 3)) begin
                n_err++;
                $display("FAIL nt1_c%0d: s_ready=%b w_en=%b m_valid=%b want %b/%b/%b", cyc,
                         s_ready1, w_en1, m_valid1, cyc % 4 == 0, cyc % 4 == 1, cyc % 4 == 3);
            end
            if (cyc % 4 == 3) begin
                n_vec++;
                if (m_y1 !== {19'd10, 19'd10}) begin
                    n_err++;
                    $display("FAIL nt1_y_c%0d: got %h want %h", cyc, m_y1, {19'd10, 19'd10});
                end
            end
            @(negedge clk);
        end
        s_valid1 = 1'b0;
        m_ready1 = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        s_valid = 1'b0; s_x = '0; m_ready = 1'b0;
        s_valid1 = 1'b0; s_x1 = '0; m_ready1 = 1'b0;
        test_reset();
        test_basic();
        test_extreme();
        test_fetch_pattern();
        test_backpressure();
        test_reset_mid_run();
        test_nt1_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
